// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA write sequencer.
package dma_pkg;

    localparam int WR_LEN_W      = 5;
    localparam int DEF_MAX_CHUNK = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH,
        ABORT
    } dma_state_e;

endpackage

// File: rtl/dma_chunk_calc.sv
// Combinational chunk length: the smaller of the bytes left and the room
// remaining before the next MAX_CHUNK-aligned boundary.
module dma_chunk_calc
    import dma_pkg::*;
#(
    parameter int MAX_CHUNK = DEF_MAX_CHUNK,
    parameter int CNT_W     = 16
) (
    input  logic [31:0]         cur_addr,
    input  logic [CNT_W-1:0]    remaining,
    output logic [WR_LEN_W-1:0] chunk
);

    localparam int OFF_W = $clog2(MAX_CHUNK);

    logic [CNT_W:0] room;
    logic [CNT_W:0] rem_x;
    logic [CNT_W:0] len_x;

    always_comb begin
        room  = (CNT_W+1)'(MAX_CHUNK) - (CNT_W+1)'(cur_addr[OFF_W-1:0]);
        rem_x = {1'b0, remaining};
        len_x = (rem_x < room) ? rem_x : room;
        chunk = len_x[WR_LEN_W-1:0];
    end

    // Upper address bits and the wide result's high bits never affect the 1..MAX_CHUNK result.
    logic unused_bits;
    assign unused_bits = ^{cur_addr[31:OFF_W], len_x[CNT_W:WR_LEN_W]};

endmodule

// File: rtl/dma_write_sequencer.sv
// Splits a DMA write into boundary-aligned chunks and hands them to the write block one at a time.
// Optional watchdog on the write-block handshake: define DMA_SEQ_WATCHDOG_EN.
module dma_write_sequencer
    import dma_pkg::*;
#(
    parameter int MAX_CHUNK   = DEF_MAX_CHUNK,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         dst_addr,
    input  logic [CNT_W-1:0]    byte_count,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                aborted,
`ifdef DMA_SEQ_WATCHDOG_EN
    output logic                err,
`endif
    output logic                wr_trigger,
    output logic [WR_LEN_W-1:0] wr_length,
    output logic [31:0]         wr_address,
    input  logic                wr_done,
    output logic [CNT_W-1:0]    chunks_issued
);

    dma_state_e          state, state_d;
    logic [31:0]         cur_addr;
    logic [CNT_W-1:0]    remaining, rem_next;
    logic [WR_LEN_W-1:0] chunk;
    logic                abort_pend;
    logic                accept, issue, step, wdog_trip;

    dma_chunk_calc #(.MAX_CHUNK(MAX_CHUNK), .CNT_W(CNT_W)) u_calc (
        .cur_addr  (cur_addr),
        .remaining (remaining),
        .chunk     (chunk)
    );

`ifdef DMA_SEQ_WATCHDOG_EN
    logic [31:0] wdog_cnt;
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
`endif

    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        issue     = 1'b0;
        step      = 1'b0;
        wdog_trip = 1'b0;
        rem_next  = remaining - CNT_W'(chunk);
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (byte_count == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d = ABORT;
                end else begin
                    issue   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The first WAIT cycle carries the trigger; a done there is not for this chunk.
                if (wr_done && !wr_trigger) begin
                    step = 1'b1;
                    if (rem_next == '0)
                        state_d = FINISH;
                    else if (abort || abort_pend)
                        state_d = ABORT;
                    else
                        state_d = ISSUE;
                end
`ifdef DMA_SEQ_WATCHDOG_EN
                else if (wdog_cnt == 32'(WDOG_CYCLES - 1)) begin
                    wdog_trip = 1'b1;
                    state_d   = ABORT;
                end
`endif
            end
            FINISH:  state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            abort_pend    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            wr_trigger    <= 1'b0;
            wr_length     <= '0;
            wr_address    <= '0;
            chunks_issued <= '0;
        end else begin
            state      <= state_d;
            busy       <= (state_d != IDLE);
            wr_trigger <= issue;
            done       <= (state == FINISH);
            aborted    <= (state == ABORT);
            if (accept) begin
                cur_addr      <= dst_addr;
                remaining     <= byte_count;
                chunks_issued <= '0;
                abort_pend    <= 1'b0;
            end
            if (issue) begin
                wr_address    <= cur_addr;
                wr_length     <= chunk;
                chunks_issued <= chunks_issued + 1'b1;
            end
            if (step) begin
                cur_addr  <= cur_addr + 32'(chunk);
                remaining <= rem_next;
            end
            // An abort seen mid-chunk is remembered until that chunk's done arrives.
            if (state == WAIT && abort)
                abort_pend <= 1'b1;
        end
    end

`ifdef DMA_SEQ_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (issue)
                wdog_cnt <= '0;
            else if (state == WAIT)
                wdog_cnt <= wdog_cnt + 1'b1;
            if (accept)
                err <= 1'b0;
            else if (wdog_trip)
                err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/dma_write_sequencer.md
Name: dma_write_sequencer

Overview:
- Splits one DMA write request into chunks of at most MAX_CHUNK bytes.
- Issues each chunk to the write block as a trigger/length/address command and waits for that block's done before issuing the next.
- Sits between the DMA register/control logic and the write block.
- Chunks never cross a MAX_CHUNK-aligned boundary.

Parameters:
- MAX_CHUNK, 16, max bytes per write-block command; power of two, 4..16.
- CNT_W, 16, width of the total byte count.
- WDOG_CYCLES, 1024, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- dst_addr  in  32  unaligned destination start address; sampled on an accepted start
- byte_count  in  CNT_W  total bytes to write; sampled on an accepted start
- abort  in  1  cancel the transfer in progress
- busy  out  1  high from the cycle after an accepted start until returning to IDLE
- done  out  1  one-cycle pulse when all bytes are written
- aborted  out  1  one-cycle pulse when an abort completes
- wr_trigger  out  1  one-cycle command strobe to the write block
- wr_length  out  5  chunk length in bytes, 1..MAX_CHUNK
- wr_address  out  32  chunk start address
- wr_done  in  1  write-block completion pulse
- chunks_issued  out  CNT_W  count of chunks triggered in the current transfer

Behaviour:
- Reset is synchronous and active-high. Reset values:
  - busy, done, aborted, wr_trigger: 0.
  - wr_length, wr_address, chunks_issued: 0.
  - State: IDLE.
  - Reset mid-transfer drops everything without a done or aborted pulse.
- IDLE:
  - start=1 latches cur_addr=dst_addr and remaining=byte_count, and clears chunks_issued.
  - If byte_count==0: go to FINISH; no wr_trigger is ever issued.
  - Otherwise: go to ISSUE.
  - start while not IDLE is ignored.
- Chunk length:
  - chunk = min(remaining, MAX_CHUNK - (cur_addr mod MAX_CHUNK)).
  - Compute at CNT_W+1 bits, then truncate to 5 bits. The result is always 1..MAX_CHUNK.
- ISSUE (one cycle):
  - Assert wr_trigger=1.
  - Drive wr_address=cur_addr and wr_length=chunk, registered.
  - Increment chunks_issued.
  - Go to WAIT.
- WAIT:
  - wr_address and wr_length are held stable.
  - On wr_done=1: cur_addr += chunk (32-bit, wraps modulo 2^32); remaining -= chunk.
  - If the new remaining==0, go to FINISH; else go to ISSUE.
  - Minimum gap between consecutive wr_trigger pulses is therefore 2 cycles after wr_done.
- FINISH (one cycle): done=1, busy=0 next, go to IDLE.
- wr_done outside WAIT, including in the same cycle as wr_trigger, is ignored.
- abort:
  - abort=1 in ISSUE: no trigger is issued; go to ABORT.
  - abort=1 in WAIT: let the in-flight chunk finish. Stay in WAIT until wr_done, then go to ABORT without issuing further chunks.
  - ABORT (one cycle): aborted=1, then IDLE.
  - abort in IDLE or FINISH is ignored.
  - abort takes priority over the FINISH path in the same cycle only if remaining would still be non-zero.
- busy = (state != IDLE), registered.
- done and aborted are never asserted in the same cycle.
- Address wrap past 0xFFFFFFFF is legal and not flagged.

Optional Feature:
- Macro: DMA_SEQ_WATCHDOG_EN.
- With the macro:
  - Adds output port err (1 bit, reset 0).
  - A counter increments each cycle in WAIT and clears on ISSUE.
  - Reaching WDOG_CYCLES sets err=1 (sticky until the next accepted start or reset) and forces ABORT; aborted pulses.
- Without the macro: no err port, no counter; WAIT waits indefinitely.

Decomposition:
- Shared package dma_pkg:
  - State enum (IDLE, ISSUE, WAIT, FINISH, ABORT).
  - WR_LEN_W=5.
  - Default MAX_CHUNK constant.
- Sub-module dma_chunk_calc: combinational chunk-length computation (cur_addr, remaining -> chunk). Unit-testable on its own.
- The FSM, counters and registers stay in dma_write_sequencer.

Test Plan:
- dst_addr=0x1000, byte_count=16 -> one trigger (addr 0x1000, len 16); done 1 cycle after the FINISH entry; chunks_issued=1.
- dst_addr=0x1003, byte_count=40 -> triggers (0x1003,13), (0x1010,16), (0x1020,11); done once; chunks_issued=3.
- byte_count=0 -> done pulses with zero wr_trigger; busy high exactly one cycle.
- Abort asserted during WAIT of chunk 2 of a 3-chunk transfer -> chunk 2's wr_done accepted; no third trigger; aborted=1; done never asserted.
- wr_done pulsed in IDLE, plus start during busy -> both ignored; no extra trigger; latched address unchanged.
- With DMA_SEQ_WATCHDOG_EN and WDOG_CYCLES=8, wr_done withheld -> err=1 and aborted=1 after 8 WAIT cycles; err clears on the next start.
